// File: rtl/cache_fill_ctrl_if.sv
// Bundles the cache-side miss signals, the memory read channel and the
// data/tag array write strobes used by cache_fill_ctrl.
// master: the fill controller. slave: the cache/memory environment.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8
);
    localparam int WI = $clog2(WORDS_PER_LINE);

    // cache miss side
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;

    // memory read channel
    logic              mem_req;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_data_valid;

    // data / tag array write strobes
    logic              wen_data;
    logic [WI-1:0]     word_enable;
    logic              wen_tag;
    logic              fill_done;

    modport master (
        input  miss_detected, miss_address, mem_ready, mem_data_valid,
        output fsm_busy, mem_req, mem_address, wen_data, word_enable,
               wen_tag, fill_done
    );

    modport slave (
        output miss_detected, miss_address, mem_ready, mem_data_valid,
        input  fsm_busy, mem_req, mem_address, wen_data, word_enable,
               wen_tag, fill_done
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller.
// On a miss it captures the line base, issues one memory read per accepted
// request, writes every returned word into the data array and finally
// writes the tag. Requests and returns are tracked by independent counters
// so issue and receive overlap.
// Optional feature macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> the fill starts at the missed word and wraps around the line
//   undefined -> the fill always runs word 0 .. WORDS_PER_LINE-1
module cache_fill_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int WORD_BYTES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_fill_ctrl_if.master  bus
);
    localparam int WI  = $clog2(WORDS_PER_LINE);
    localparam int WB  = $clog2(WORD_BYTES);
    localparam int OFF = WI + WB;

    localparam logic [WI:0]       CNT_ONE   = (WI+1)'(1);
    localparam logic [WI:0]       CNT_FULL  = (WI+1)'(WORDS_PER_LINE);
    localparam logic [WI:0]       CNT_LAST  = (WI+1)'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_base, w_base_next;
    logic [WI:0]       r_issue_cnt, w_issue_cnt_next;
    logic [WI:0]       r_rx_cnt, w_rx_cnt_next;

    logic [WI-1:0]     w_start;       // first word of the current fill
    logic [WI-1:0]     w_issue_idx;   // word index of the pending request
    logic [WI-1:0]     w_rx_idx;      // word index of the next returned word
    logic [ADDR_W-1:0] w_line_base;   // miss address with the in-line offset cleared
    logic [ADDR_W-1:0] w_word_offset; // byte offset of w_issue_idx inside the line
    logic [ADDR_W-1:0] w_req_address;
    logic              w_miss_accept;
    logic              w_mem_req;
    logic              w_issue_fire;
    logic              w_rx_accept;

    logic              w_fsm_busy;
    logic [ADDR_W-1:0] w_mem_address;
    logic              w_wen_data;
    logic [WI-1:0]     w_word_enable;
    logic              w_wen_tag;

    assign w_miss_accept = (r_state == ST_IDLE) && bus.miss_detected;
    assign w_line_base   = bus.miss_address & ~LINE_MASK;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [WI-1:0] r_start;

    // Remember which word missed so the fill begins there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start <= '0;
        end else if (w_miss_accept) begin
            r_start <= bus.miss_address[OFF-1:WB];
        end
    end

    assign w_start = r_start;
`else
    assign w_start = '0;
`endif

    // Word indices wrap naturally in WI bits, i.e. modulo WORDS_PER_LINE.
    assign w_issue_idx = w_start + r_issue_cnt[WI-1:0];
    assign w_rx_idx    = w_start + r_rx_cnt[WI-1:0];

    // Place the word index above the byte-in-word bits; everything else is 0,
    // so OR-ing with the line base can never carry out of the line.
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_word_offset
        if (gi >= WB && gi < OFF) begin : g_idx_bit
            assign w_word_offset[gi] = w_issue_idx[gi-WB];
        end else begin : g_zero_bit
            assign w_word_offset[gi] = 1'b0;
        end
    end

    assign w_req_address = r_base | w_word_offset;
    assign w_mem_req     = (r_state == ST_FILL) && (r_issue_cnt < CNT_FULL);
    assign w_issue_fire  = w_mem_req && bus.mem_ready;
    // Only registered counts decide whether a word is outstanding, so a
    // request accepted in this very cycle cannot be matched by this valid.
    assign w_rx_accept   = (r_state == ST_FILL) && bus.mem_data_valid &&
                           (r_rx_cnt < r_issue_cnt);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Line base and issue/receive counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_rx_cnt    <= '0;
        end else begin
            r_base      <= w_base_next;
            r_issue_cnt <= w_issue_cnt_next;
            r_rx_cnt    <= w_rx_cnt_next;
        end
    end

    // Next state, datapath updates and all outputs.
    always_comb begin
        w_state_next     = r_state;
        w_base_next      = r_base;
        w_issue_cnt_next = r_issue_cnt;
        w_rx_cnt_next    = r_rx_cnt;
        w_fsm_busy       = 1'b0;
        w_mem_address    = '0;
        w_wen_data       = 1'b0;
        w_word_enable    = '0;
        w_wen_tag        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The miss cycle itself already stalls the cache.
                w_fsm_busy = bus.miss_detected;
                if (w_miss_accept) begin
                    w_state_next     = ST_FILL;
                    w_base_next      = w_line_base;
                    w_issue_cnt_next = '0;
                    w_rx_cnt_next    = '0;
                end
            end

            ST_FILL: begin
                w_fsm_busy = 1'b1;
                // Address is only driven while a request is pending.
                if (w_mem_req) begin
                    w_mem_address = w_req_address;
                end
                if (w_issue_fire) begin
                    w_issue_cnt_next = r_issue_cnt + CNT_ONE;
                end
                if (w_rx_accept) begin
                    w_wen_data    = 1'b1;
                    w_word_enable = w_rx_idx;
                    w_rx_cnt_next = r_rx_cnt + CNT_ONE;
                    if (r_rx_cnt == CNT_LAST) begin
                        w_state_next = ST_TAG;
                    end
                end
            end

            ST_TAG: begin
                w_fsm_busy   = 1'b1;
                w_wen_tag    = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.fsm_busy    = w_fsm_busy;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_address = w_mem_address;
    assign bus.wen_data    = w_wen_data;
    assign bus.word_enable = w_word_enable;
    assign bus.wen_tag     = w_wen_tag;
    assign bus.fill_done   = w_wen_tag;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Testbench for cache_fill_ctrl: a vector table for the basic fill, directed
// stall / reset sequences, a randomized run against a queue-based reference
// model, and a small-geometry instance (4 words of 4 bytes, 32-bit address).
module tb_cache_fill_ctrl;
    localparam int AW  = 16;
    localparam int WPL = 8;
    localparam int WB  = 2;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    // Start word of a 0x1234 miss (word 2) and of a 0x108 miss in the small line.
    localparam int TS  = CWF ? 2 : 0;
    localparam int TS2 = CWF ? 2 : 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(AW), .WORDS_PER_LINE(WPL)) bus ();
    cache_fill_ctrl #(.ADDR_W(AW), .WORDS_PER_LINE(WPL), .WORD_BYTES(WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cache_fill_ctrl_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus2 ();
    cache_fill_ctrl #(.ADDR_W(32), .WORDS_PER_LINE(4), .WORD_BYTES(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {busy, req, addr[15:0], wen_data, word_enable[2:0], wen_tag, fill_done}
    function automatic logic [23:0] dut_out();
        return {bus.fsm_busy, bus.mem_req, bus.mem_address, bus.wen_data,
                bus.word_enable, bus.wen_tag, bus.fill_done};
    endfunction

    function automatic logic [38:0] dut2_out();
        return {bus2.fsm_busy, bus2.mem_req, bus2.mem_address, bus2.wen_data,
                bus2.word_enable, bus2.wen_tag, bus2.fill_done};
    endfunction

    // ---------------- reference model (line-fill behaviour) ----------------
    int          cyc;
    bit          m_fill, m_tag;
    logic [15:0] m_base;
    int          m_s, m_issued, m_rx;
    int          oq[$];   // word indices requested but not yet returned
    int          due[$];  // cycle at which each outstanding word returns
    logic [23:0] s_out;   // DUT outputs sampled in the last step

    task automatic model_clear();
        m_fill = 0; m_tag = 0; m_base = '0; m_s = 0; m_issued = 0; m_rx = 0;
        oq.delete(); due.delete();
    endtask

    // One clock cycle: drive, compare against the model, clock, update model.
    task automatic step(input logic miss, input logic [15:0] maddr, input logic ready,
                        input logic spur, input logic rst_lo, input int lat);
        logic        valid, e_req, e_wd, e_busy;
        logic [15:0] e_addr;
        logic [2:0]  e_we;
        int          d;
        valid = (due.size() > 0 && due[0] <= cyc) || (spur && oq.size() == 0);
        rst_n = ~rst_lo;
        bus.miss_detected  = miss;
        bus.miss_address   = maddr;
        bus.mem_ready      = ready;
        bus.mem_data_valid = valid;
        #1;
        e_req  = m_fill && (m_issued < WPL);
        e_addr = e_req ? m_base + 16'(((m_s + m_issued) % WPL) * WB) : 16'h0;
        e_wd   = m_fill && valid && (oq.size() > 0);
        e_we   = e_wd ? 3'(oq[0]) : 3'd0;
        e_busy = m_fill || m_tag || miss;
        s_out  = dut_out();
        check($sformatf("outputs@cyc%0d", cyc), 64'(s_out),
              64'({e_busy, e_req, e_addr, e_wd, e_we, m_tag, m_tag}));
        @(posedge clk);
        if (rst_lo) begin
            model_clear();
        end else if (m_tag) begin
            m_tag = 0;
        end else if (!m_fill) begin
            if (miss) begin
                m_fill = 1; m_issued = 0; m_rx = 0;
                m_base = maddr & 16'hFFF0;
                m_s    = CWF ? int'((maddr >> 1) & 16'h7) : 0;
                oq.delete(); due.delete();
            end
        end else begin
            if (e_wd) begin
                void'(oq.pop_front());
                if (due.size() > 0 && due[0] <= cyc) void'(due.pop_front());
                m_rx++;
                if (m_rx == WPL) begin
                    m_fill = 0;
                    m_tag  = 1;
                end
            end
            if (e_req && ready) begin
                oq.push_back((m_s + m_issued) % WPL);
                m_issued++;
                d = cyc + lat;
                if (due.size() > 0 && d <= due[$]) d = due[$] + 1;
                due.push_back(d);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_lo;
        logic        miss;
        logic [15:0] maddr;
        logic        ready;
        logic        valid;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int          c, writes, tags;
        logic        req, wd, busy, tag;
        logic [15:0] addr;
        logic [2:0]  we;
        logic [38:0] e2;
        logic [31:0] a2;
        logic [1:0]  we2;

        rst_n = 1'b0;
        bus.miss_detected = 0; bus.miss_address = '0; bus.mem_ready = 0; bus.mem_data_valid = 0;
        bus2.miss_detected = 0; bus2.miss_address = '0; bus2.mem_ready = 0; bus2.mem_data_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Rows 0/1: reset held low; only fsm_busy may follow miss_detected.
        tbl[0] = '{rst_lo: 1, miss: 0, maddr: 16'h0,    ready: 0, valid: 1, exp: 24'h0};
        tbl[1] = '{rst_lo: 1, miss: 1, maddr: 16'h1234, ready: 1, valid: 1, exp: 24'h800000};
        // Rows 2..17: cycles -1..14 of a 0x1234 miss, ready high, 4-cycle latency,
        // with a spurious valid in IDLE (-1) and one with nothing outstanding (1).
        for (int i = 2; i < 18; i++) begin
            c    = i - 3;
            req  = (c >= 1 && c <= 8);
            addr = req ? 16'h1230 + 16'(((TS + c - 1) % 8) * 2) : 16'h0;
            wd   = (c >= 5 && c <= 12);
            we   = wd ? 3'((TS + c - 5) % 8) : 3'd0;
            tag  = (c == 13);
            busy = (c >= 0 && c <= 13);
            tbl[i].rst_lo = 0;
            tbl[i].miss   = (c == 0);
            tbl[i].maddr  = (c == 0) ? 16'h1234 : 16'hFFFF;
            tbl[i].ready  = 1;
            tbl[i].valid  = wd || (c == -1) || (c == 1);
            tbl[i].exp    = {busy, req, addr, wd, we, tag, tag};
        end

        for (int i = 0; i < 18; i++) begin
            rst_n              = ~tbl[i].rst_lo;
            bus.miss_detected  = tbl[i].miss;
            bus.miss_address   = tbl[i].maddr;
            bus.mem_ready      = tbl[i].ready;
            bus.mem_data_valid = tbl[i].valid;
            #1;
            $display("vec %0d: out=%h exp=%h", i, dut_out(), tbl[i].exp);
            check($sformatf("vec%0d", i), 64'(dut_out()), 64'(tbl[i].exp));
            @(posedge clk);
            @(negedge clk);
        end

        cyc = 0;
        model_clear();

        // ---- stall: mem_ready low on cycles 2-3 ----
        writes = 0; tags = 0;
        step(1, 16'h1234, 1, 0, 0, 4);
        for (int k = 1; k < 30; k++) begin
            step(0, 16'hFFFF, (k != 2 && k != 3), 0, 0, 4);
            if (k >= 1 && k <= 4)
                check($sformatf("stall_addr_c%0d", k), 64'(s_out[21:6]),
                      64'(16'h1230 + 16'(((TS + (k == 1 ? 0 : 1)) % 8) * 2)));
            writes += int'(s_out[5]);
            tags   += int'(s_out[1]);
        end
        $display("stall fill: writes=%0d tags=%0d", writes, tags);
        check("stall_writes", 64'(writes), 64'(8));
        check("stall_tags",   64'(tags),   64'(1));

        // ---- reset at cycle 6 of a fill ----
        tags = 0;
        step(1, 16'h1234, 1, 0, 0, 3);
        for (int k = 1; k <= 5; k++) begin
            step(0, 16'h1234, 1, 0, 0, 3);
            tags += int'(s_out[1]);
        end
        step(0, 16'h1234, 1, 0, 1, 3);
        tags += int'(s_out[1]);
        step(0, 16'h1234, 1, 1, 0, 3);
        check("reset_outputs_zero", 64'(s_out), 64'(0));
        check("reset_no_tag", 64'(tags + int'(s_out[1])), 64'(0));
        writes = 0; tags = 0;
        step(1, 16'h2468, 1, 0, 0, 2);
        step(0, 16'h0000, 1, 0, 0, 2);
        check("restart_addr", 64'(s_out[21:6]), 64'(16'h2460 + 16'((CWF ? 4 : 0) * 2)));
        for (int k = 0; k < 20; k++) begin
            step(0, 16'h0000, 1, 0, 0, 2);
            writes += int'(s_out[5]);
            tags   += int'(s_out[1]);
        end
        $display("restart fill: writes=%0d tags=%0d", writes, tags);
        check("restart_writes", 64'(writes), 64'(8));
        check("restart_tags",   64'(tags),   64'(1));

        // ---- randomized run against the model ----
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 4) == 0, 16'($urandom), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, ($urandom % 300) == 0, int'($urandom_range(1, 6)));
        end
        step(0, 16'h0, 0, 0, 1, 1);
        step(0, 16'h0, 0, 0, 0, 1);

        // ---- small geometry: 4 words x 4 bytes, miss 0x108, latency 1 ----
        bus2.miss_detected = 1; bus2.miss_address = 32'h0000_0108; bus2.mem_ready = 1;
        bus2.mem_data_valid = 0;
        #1;
        check("g4_miss_busy", 64'(dut2_out()), 64'({1'b1, 38'h0}));
        @(posedge clk);
        @(negedge clk);
        bus2.miss_detected = 0; bus2.miss_address = 32'hDEAD_BEEF;
        for (int k = 1; k <= 7; k++) begin
            wd  = (k >= 2 && k <= 5);
            req = (k <= 4);
            a2  = req ? 32'h100 + 32'(((TS2 + k - 1) % 4) * 4) : 32'h0;
            we2 = wd ? 2'((TS2 + k - 2) % 4) : 2'd0;
            tag = (k == 6);
            bus2.mem_data_valid = wd;
            #1;
            e2 = {(k <= 6), req, a2, wd, we2, tag, tag};
            $display("g4 cycle %0d: out=%h exp=%h", k, dut2_out(), e2);
            check($sformatf("g4_c%0d", k), 64'(dut2_out()), 64'(e2));
            @(posedge clk);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised cache line-fill controller between the cache miss logic and the multi-cycle main memory. On a miss it captures the line address, issues one memory word-read per accepted request, and writes each returned word into the data array. After the last word it writes the tag. Generalises the fixed 8-word/16-bit fill FSM with configurable geometry, a memory-ready handshake, decoupled issue/receive counters, and optional critical-word-first ordering.

## Interface
- ADDR_W, 16, byte-address width
- WORDS_PER_LINE, 8, words per cache line; power of two, 2..64
- WORD_BYTES, 2, bytes per word; power of two
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- miss_detected  in  1  cache miss this cycle; sampled only in IDLE
- miss_address  in  ADDR_W  missing byte address; captured with miss_detected
- fsm_busy  out  1  fill in progress; cache must stall
- mem_req  out  1  read request valid
- mem_ready  in  1  memory accepts the request this cycle
- mem_address  out  ADDR_W  word-aligned byte address of the current request
- mem_data_valid  in  1  one returned word this cycle, in request order
- wen_data  out  1  write the returned word into the data array
- word_enable  out  log2(WORDS_PER_LINE)  word index for wen_data
- wen_tag  out  1  write the tag/valid bit for the captured line
- fill_done  out  1  one-cycle pulse; equals wen_tag

## Operation
- OFF = log2(WORDS_PER_LINE*WORD_BYTES). WI = log2(WORDS_PER_LINE).
- States: IDLE, FILL, TAG.
- **IDLE**
  - On miss_detected: capture line base = miss_address with OFF low bits zeroed.
  - Capture start word s: 0, or miss_address[OFF-1:log2(WORD_BYTES)] with CWF.
  - Clear issue_cnt and rx_cnt, then go to FILL.
- **FILL**
  - mem_req = (issue_cnt < WORDS_PER_LINE).
  - mem_address = base + ((s+issue_cnt) mod WORDS_PER_LINE)*WORD_BYTES.
  - issue_cnt increments when mem_req & mem_ready.
  - A word is accepted when mem_data_valid & (rx_cnt < issue_cnt). The check uses registered counts, so a request accepted in the same cycle does not qualify.
  - On an accepted word: wen_data=1, word_enable=(s+rx_cnt) mod WORDS_PER_LINE, and rx_cnt increments.
  - An unaccepted valid (nothing outstanding) is ignored: no write and no count.
  - When the accepted word is the last one (rx_cnt==WORDS_PER_LINE-1), go to TAG.
- **TAG**
  - wen_tag=1 and fill_done=1 for exactly one cycle, then return to IDLE.
- miss_detected is ignored in FILL and TAG. miss_address changes after capture have no effect.
- fsm_busy = (state!=IDLE) | (state==IDLE & miss_detected). It covers the miss cycle through the TAG cycle inclusive.
- Counters are WI+1 bits wide. Word index arithmetic wraps modulo WORDS_PER_LINE. Address arithmetic never carries out of the line.
- mem_data_valid in IDLE or TAG is ignored.

## Timing
- Reset (rst_n low at a clk edge): state=IDLE, counters=0, base=0, s=0.
  - All outputs 0 except that fsm_busy follows miss_detected combinationally.
- Reset mid-fill: abort immediately with no wen_tag. Returning words after reset are ignored.
- Miss accepted at cycle 0: mem_req high from cycle 1.
- With mem_ready tied high, requests issue on cycles 1..WORDS_PER_LINE.
- Last word accepted at cycle N (wen_data at N): wen_tag at N+1, IDLE and fsm_busy low at N+2. A new miss is accepted at N+2.
- mem_ready low holds mem_address and mem_req stable.
- Issue and receive proceed concurrently. Data may return the cycle after its request is accepted, or later.
- wen_data and word_enable are combinational from mem_data_valid and registered counters. No extra latency.

## Configuration
- CACHE_FILL_CRITICAL_WORD_FIRST_EN
  - Defined: s = missed word index. Requests and writes wrap, e.g. for 8 words, s=5 gives order 5,6,7,0,1,2,3,4.
  - Undefined: s=0 always. Order is 0..WORDS_PER_LINE-1 regardless of the miss offset. The s register is removed.

## Test plan
- Default params, no CWF, miss_address=0x1234, mem_ready=1, 4-cycle data latency:
  - mem_address 0x1230,0x1232,…,0x123E on cycles 1–8.
  - wen_data with word_enable 0..7 on cycles 5–12.
  - wen_tag on cycle 13; fsm_busy low on cycle 14.
- Same miss with mem_ready low on cycles 2–3:
  - mem_address holds 0x1232 through cycle 4.
  - No issue_cnt advance during the stall.
  - Exactly 8 writes and one wen_tag.
- CWF defined, miss_address=0x123A:
  - Addresses 0x123A,0x123C,0x123E,0x1230…0x1238.
  - word_enable 5,6,7,0,1,2,3,4.
- Spurious mem_data_valid in IDLE, and valid with nothing outstanding in FILL cycle 1 -> no wen_data, rx_cnt unchanged.
- rst_n low at cycle 6 of a fill -> all outputs 0 at cycle 7; no wen_tag. The next miss restarts at word 0 with the new address.
- WORDS_PER_LINE=4, WORD_BYTES=4, ADDR_W=32, miss 0x0000_0108 -> addresses 0x100,0x104,0x108,0x10C; wen_tag after the 4th word.
